// File: rtl/hex_sr_ctrl.sv
// ---------------------------------------------------------------------------
// hex_sr_ctrl
//
// Controller for an external recirculating shift register of LENGTH 6-bit
// slots. The register rotates one slot per clock, and the slot at its head
// is tracked by `pos`. A write is applied by replacing the head value as it
// goes past. A read is done by capturing the head value as it goes past.
// After reset, and on request, a CLEAR pass loads zeros into every slot
// during one full rotation.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   wr_req/addr/data    write request, held until wr_ack
//   wr_ack              one-cycle write acknowledge
//   rd_req/addr         read request, held until rd_ack
//   rd_ack, rd_data     one-cycle read acknowledge, last value read
//   err                 pulses with an ack when the address was out of range
//   clr_req             clear command (ignored while clearing)
//   sr_recirc           1 = recirculate head, 0 = load sr_din into the slot
//   sr_din              value to load into the current head slot
//   sr_dout             current head value of the shift register
//   pos                 index of the slot at the head this cycle
//   busy                high while clearing
// ---------------------------------------------------------------------------
module hex_sr_ctrl #(
   parameter int unsigned LENGTH = 40
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_req,
   input  logic [5:0] wr_addr,
   input  logic [5:0] wr_data,
   output logic       wr_ack,
   input  logic       rd_req,
   input  logic [5:0] rd_addr,
   output logic       rd_ack,
   output logic [5:0] rd_data,
   output logic       err,
   input  logic       clr_req,
   output logic       sr_recirc,
   output logic [5:0] sr_din,
   input  logic [5:0] sr_dout,
   output logic [5:0] pos,
   output logic       busy
);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   localparam logic [5:0] LAST = 6'(LENGTH - 1);

   state_e     state_q, state_d;
   logic [5:0] clr_cnt_q, clr_cnt_d;
   logic [5:0] pos_q, pos_d;

   logic       wr_pend_q, wr_pend_d;
   logic [5:0] wr_addr_q, wr_addr_d;
   logic [5:0] wr_data_q, wr_data_d;
   logic       rd_pend_q, rd_pend_d;
   logic [5:0] rd_addr_q, rd_addr_d;

   logic       wr_ack_q, wr_ack_d;
   logic       rd_ack_q, rd_ack_d;
   logic       err_q, err_d;
   logic [5:0] rd_data_q, rd_data_d;

   logic       wr_latch, wr_bad, wr_hit;
   logic       rd_latch, rd_bad, rd_hit;

   // A port accepts a new request only when nothing is pending for it and
   // its previous ack is not still showing. This way a request that is
   // still held during its own ack cycle is not taken a second time.
   assign wr_latch = wr_req && !wr_pend_q && !wr_ack_q;
   assign rd_latch = rd_req && !rd_pend_q && !rd_ack_q;
   assign wr_bad   = 32'(wr_addr) >= LENGTH;
   assign rd_bad   = 32'(rd_addr) >= LENGTH;

   // A pending access is serviced when its slot reaches the head. This only
   // happens in RUN. A read and a write to the same slot can both hit in the
   // same cycle, and the read then captures the value from before the write.
   assign wr_hit = (state_q == RUN) && wr_pend_q && (wr_addr_q == pos_q);
   assign rd_hit = (state_q == RUN) && rd_pend_q && (rd_addr_q == pos_q);

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d   = state_q;
      clr_cnt_d = '0;
      pos_d     = (pos_q == LAST) ? 6'd0 : 6'(pos_q + 6'd1);

      sr_recirc = 1'b1;
      sr_din    = '0;

      unique case (state_q)
         CLEAR: begin
            sr_recirc = 1'b0;
            if (clr_cnt_q == LAST) state_d   = RUN;
            else                   clr_cnt_d = 6'(clr_cnt_q + 6'd1);
         end
         RUN: begin
            if (clr_req) state_d = CLEAR;
            if (wr_hit) begin
               sr_recirc = 1'b0;
               sr_din    = wr_data_q;
            end
         end
         default: state_d = CLEAR;
      endcase

      wr_pend_d = wr_pend_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (wr_latch) begin
         wr_addr_d = wr_addr;
         wr_data_d = wr_data;
         wr_pend_d = !wr_bad;
      end else if (wr_hit) begin
         wr_pend_d = 1'b0;
      end

      rd_pend_d = rd_pend_q;
      rd_addr_d = rd_addr_q;
      if (rd_latch) begin
         rd_addr_d = rd_addr;
         rd_pend_d = !rd_bad;
      end else if (rd_hit) begin
         rd_pend_d = 1'b0;
      end

      rd_data_d = rd_hit ? sr_dout : rd_data_q;

      // Out-of-range requests are answered right away and never become
      // pending, so the shift register and rd_data are left unchanged.
      wr_ack_d = wr_hit || (wr_latch && wr_bad);
      rd_ack_d = rd_hit || (rd_latch && rd_bad);
      err_d    = (wr_latch && wr_bad) || (rd_latch && rd_bad);
   end

   // NOTE: sequential state uses non-blocking assignments only. Then every
   // register samples the values from before the edge, whatever order the
   // simulator runs the blocks in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
         pos_q     <= '0;
         wr_pend_q <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_pend_q <= 1'b0;
         rd_addr_q <= '0;
         wr_ack_q  <= 1'b0;
         rd_ack_q  <= 1'b0;
         err_q     <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         pos_q     <= pos_d;
         wr_pend_q <= wr_pend_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         rd_pend_q <= rd_pend_d;
         rd_addr_q <= rd_addr_d;
         wr_ack_q  <= wr_ack_d;
         rd_ack_q  <= rd_ack_d;
         err_q     <= err_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign wr_ack  = wr_ack_q;
   assign rd_ack  = rd_ack_q;
   assign err     = err_q;
   assign rd_data = rd_data_q;
   assign pos     = pos_q;
   assign busy    = (state_q == CLEAR);

endmodule

// File: tb/tb_hex_sr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hex_sr_ctrl
//
// Directed bench for hex_sr_ctrl with LENGTH = 40. A behavioural
// recirculating shift register is attached to the sr_* ports. Its slots
// start out non-zero, so the clear pass has to zero them for reads to come
// back as 0. The bench drives inputs and samples outputs on the falling
// clock edge.
// ---------------------------------------------------------------------------
module tb_hex_sr_ctrl;

   localparam int L = 40;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_req, rd_req, clr_req;
   logic [5:0] wr_addr, wr_data, rd_addr;
   logic       wr_ack, rd_ack, err, sr_recirc, busy;
   logic [5:0] rd_data, sr_din, sr_dout, pos;

   int n_pass   = 0;
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hex_sr_ctrl #(.LENGTH(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
      .err(err), .clr_req(clr_req),
      .sr_recirc(sr_recirc), .sr_din(sr_din), .sr_dout(sr_dout),
      .pos(pos), .busy(busy)
   );

   // Shift register model: slot 0 is the head. Each edge the head value
   // moves to the tail, either unchanged or replaced by sr_din.
   logic [5:0] sr [L] = '{default: 6'h2B};
   assign sr_dout = sr[0];

   always @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < L - 1; i++) sr[i] <= sr[i + 1];
         sr[L - 1] <= sr_recirc ? sr[0] : sr_din;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_pos(input logic [5:0] p);
      int n = 0;
      while (pos !== p && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("wait_pos timeout", 32'(pos), 32'(p));
   endtask

   // Issues one write and holds the request until it is acked. Reports the
   // number of cycles until the ack, the err value seen with the ack, and
   // the position at which the load into the shift register happened.
   task automatic write_op(input logic [5:0] a, input logic [5:0] d, output int cyc,
                           output logic e, output logic saw, output logic [5:0] lp);
      wr_req = 1'b1; wr_addr = a; wr_data = d;
      cyc = 0; saw = 1'b0; lp = '0;
      while (wr_ack !== 1'b1 && cyc < 200) begin
         if (sr_recirc === 1'b0 && busy === 1'b0) begin saw = 1'b1; lp = pos; end
         @(negedge clk);
         cyc++;
      end
      e = err;
      wr_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic read_op(input logic [5:0] a, output int cyc, output logic e,
                          output logic [5:0] d);
      rd_req = 1'b1; rd_addr = a;
      cyc = 0;
      while (rd_ack !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      e = err;
      d = rd_data;
      rd_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int         cyc, n;
      logic       e, saw;
      logic [5:0] lp, d;

      rst_n = 1'b0; wr_req = 0; rd_req = 0; clr_req = 0;
      wr_addr = 0; wr_data = 0; rd_addr = 0;

      // Values while reset is held.
      #3;
      check("reset busy", 32'(busy), 1);
      check("reset sr_recirc", 32'(sr_recirc), 0);
      check("reset pos", 32'(pos), 0);
      check("reset acks/err", {29'd0, wr_ack, rd_ack, err}, 0);
      check("reset rd_data", 32'(rd_data), 0);

      // Release reset. The clear pass must last exactly 40 cycles.
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < L; i++) begin
         if (busy === 1'b1 && sr_recirc === 1'b0 && sr_din === 6'd0) n++;
         @(negedge clk);
      end
      check("clear cycles", 32'(n), 40);
      check("run after clear busy", 32'(busy), 0);
      check("run after clear pos", 32'(pos), 0);

      // Read slot 0 latched at pos 0. This is the worst-case latency.
      read_op(6'd0, cyc, e, d);
      check("rd0 data", 32'(d), 0);
      check("rd0 err", 32'(e), 0);
      check("rd0 latency", 32'(cyc), 41);
      read_op(6'd17, cyc, e, d);
      check("rd17 data", 32'(d), 0);
      read_op(6'd39, cyc, e, d);
      check("rd39 data", 32'(d), 0);
      check("rd39 err", 32'(e), 0);

      // Write slot 5 with 0x2A, latched at pos 10.
      wait_pos(6'd10);
      write_op(6'd5, 6'h2A, cyc, e, saw, lp);
      check("wr5 load seen", 32'(saw), 1);
      check("wr5 load pos", 32'(lp), 5);
      check("wr5 ack latency", 32'(cyc), 36);
      check("wr5 err", 32'(e), 0);
      read_op(6'd5, cyc, e, d);
      check("rd5 data", 32'(d), 32'h2A);

      // Read and write of the same slot, latched in the same cycle.
      write_op(6'd7, 6'h0C, cyc, e, saw, lp);
      wr_req = 1'b1; wr_addr = 6'd7; wr_data = 6'h15;
      rd_req = 1'b1; rd_addr = 6'd7;
      cyc = 0;
      while (wr_ack !== 1'b1 && rd_ack !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("same-slot wr_ack", 32'(wr_ack), 1);
      check("same-slot rd_ack", 32'(rd_ack), 1);
      check("same-slot pre-write data", 32'(rd_data), 32'h0C);
      wr_req = 1'b0; rd_req = 1'b0;
      @(negedge clk);
      read_op(6'd7, cyc, e, d);
      check("rd7 after write", 32'(d), 32'h15);

      // Out-of-range addresses are rejected.
      write_op(6'd40, 6'h3F, cyc, e, saw, lp);
      check("wr40 latency", 32'(cyc), 1);
      check("wr40 err", 32'(e), 1);
      check("wr40 no load", 32'(saw), 0);
      write_op(6'd63, 6'h3F, cyc, e, saw, lp);
      check("wr63 err", 32'(e), 1);
      check("wr63 no load", 32'(saw), 0);
      read_op(6'd50, cyc, e, d);
      check("rd50 err", 32'(e), 1);
      check("rd50 latency", 32'(cyc), 1);
      check("rd50 data unchanged", 32'(d), 32'h15);
      read_op(6'd5, cyc, e, d);
      check("rd5 after rejects", 32'(d), 32'h2A);
      check("rd5 err", 32'(e), 0);

      // A clear command while a write of slot 3 is pending.
      wait_pos(6'd4);
      wr_req = 1'b1; wr_addr = 6'd3; wr_data = 6'h33; clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      cyc = 1; saw = 1'b0; lp = '0;
      check("clr busy", 32'(busy), 1);
      while (wr_ack !== 1'b1 && cyc < 200) begin
         if (sr_recirc === 1'b0 && busy === 1'b0) begin saw = 1'b1; lp = pos; end
         @(negedge clk);
         cyc++;
      end
      wr_req = 1'b0;
      check("clr wr latency", 32'(cyc), 80);
      check("clr wr load pos", 32'(lp), 3);
      @(negedge clk);
      read_op(6'd5, cyc, e, d);
      check("rd5 after clear", 32'(d), 0);
      read_op(6'd7, cyc, e, d);
      check("rd7 after clear", 32'(d), 0);
      read_op(6'd3, cyc, e, d);
      check("rd3 after clear", 32'(d), 32'h33);

      // Reset while a read is pending.
      wait_pos(6'd21);
      rd_req = 1'b1; rd_addr = 6'd20;
      @(negedge clk);
      check("pre-reset rd_data", 32'(rd_data), 32'h33);
      #2 rst_n = 1'b0;
      #1;
      check("async reset busy", 32'(busy), 1);
      check("async reset sr_recirc", 32'(sr_recirc), 0);
      check("async reset pos", 32'(pos), 0);
      check("async reset rd_data", 32'(rd_data), 0);
      check("async reset rd_ack", 32'(rd_ack), 0);
      rd_req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 60; i++) begin
         if (rd_ack === 1'b1) n++;
         @(negedge clk);
      end
      check("dropped read no ack", 32'(n), 0);
      read_op(6'd20, cyc, e, d);
      check("reissued rd20 data", 32'(d), 0);
      check("reissued rd20 err", 32'(e), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
